// File: rtl/glyph_line_fetcher_pkg.sv
// Shared font geometry, ROM address layout and controller state encoding
// for the text-overlay glyph line fetcher.
package glyph_line_fetcher_pkg;

  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned GLYPH_ROWS = 16;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned CODE_W     = 7;
  localparam int unsigned ROM_AW     = CODE_W + ROW_W;
  localparam int unsigned BIT_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

endpackage

// File: rtl/glyph_line_buf.sv
// One text line of prefetched glyph rows: single write port, asynchronous
// bit-select read port used by the pixel serialiser.
module glyph_line_buf
  import glyph_line_fetcher_pkg::*;
#(
  parameter int unsigned NUM_CHARS = 8,
  parameter int unsigned CIDX_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [CIDX_W-1:0]  waddr,
  input  logic [GLYPH_W-1:0] wdata,
  input  logic [CIDX_W-1:0]  raddr,
  input  logic [BIT_W-1:0]   rbit,
  output logic               rd_bit_c
);

  logic [GLYPH_W-1:0] mem [NUM_CHARS];
  logic [GLYPH_W-1:0] rd_byte;

  // Entries are matched by compare so any NUM_CHARS fits the index width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        if (waddr == CIDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < int'(NUM_CHARS); i++) begin
      if (raddr == CIDX_W'(i)) rd_byte = mem[i];
    end
  end

  assign rd_bit_c = rd_byte[rbit];

endmodule

// File: rtl/glyph_line_fetcher.sv
// Prefetches one glyph row per character from the font ROM during h-blank,
// then serialises the line MSB-first as overlay pixels during active video.
module glyph_line_fetcher
  import glyph_line_fetcher_pkg::*;
#(
  parameter int unsigned NUM_CHARS = 8,
  parameter int unsigned CIDX_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [ROW_W-1:0]   glyph_row,
  output logic [CIDX_W-1:0]  char_idx,
  input  logic [7:0]         char_code,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  input  logic               pix_en,
  input  logic               active,
  output logic               ready,
  output logic               pixel_on,
  output logic               underrun
);

  localparam int unsigned CNT_W = CIDX_W + 1;
  localparam logic [CNT_W-1:0] NCH = CNT_W'(NUM_CHARS);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic                issued_q, issued_d;
  logic [CIDX_W-1:0]   char_idx_q, char_idx_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                ready_q, ready_d;
  logic                pixel_on_q, pixel_on_d;
  logic                underrun_q, underrun_d;
  logic [CIDX_W-1:0]   ci_q, ci_d;
  logic [BIT_W-1:0]    bi_q, bi_d;
  logic                buf_we_c;
  logic                buf_bit_c;
  logic                unused_code_msb;

  // The font ROM holds 128 glyphs, so the top code bit selects nothing.
  assign unused_code_msb = char_code[7];

  glyph_line_buf #(
    .NUM_CHARS (NUM_CHARS),
    .CIDX_W    (CIDX_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .we       (buf_we_c),
    .waddr    (CIDX_W'(cap_cnt_q)),
    .wdata    (rom_data),
    .raddr    (ci_q),
    .rbit     (BIT_W'(7) - bi_q),
    .rd_bit_c (buf_bit_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      issued_q    <= 1'b0;
      char_idx_q  <= '0;
      rom_addr_q  <= '0;
      ready_q     <= 1'b0;
      pixel_on_q  <= 1'b0;
      underrun_q  <= 1'b0;
      ci_q        <= '0;
      bi_q        <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      issued_q    <= issued_d;
      char_idx_q  <= char_idx_d;
      rom_addr_q  <= rom_addr_d;
      ready_q     <= ready_d;
      pixel_on_q  <= pixel_on_d;
      underrun_q  <= underrun_d;
      ci_q        <= ci_d;
      bi_q        <= bi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    issued_d    = 1'b0;
    char_idx_d  = char_idx_q;
    rom_addr_d  = rom_addr_q;
    ready_d     = ready_q;
    pixel_on_d  = pix_en ? 1'b0 : pixel_on_q;
    underrun_d  = pix_en & active & ~((state_q == S_READY) | (state_q == S_SHOW));
    ci_d        = ci_q;
    bi_d        = bi_q;
    buf_we_c    = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        // Capture trails issue by one clock because the ROM answers the previous address.
        if (issued_q) begin
          buf_we_c  = 1'b1;
          cap_cnt_d = cap_cnt_q + CNT_W'(1);
        end
        if (issue_cnt_q < NCH) begin
          rom_addr_d  = {char_code[CODE_W-1:0], row_q};
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          issued_d    = 1'b1;
          if (issue_cnt_q < NCH - CNT_W'(1)) char_idx_d = CIDX_W'(issue_cnt_q + CNT_W'(1));
        end
        if (cap_cnt_q == NCH) begin
          state_d = S_READY;
          ready_d = 1'b1;
          ci_d    = '0;
          bi_d    = '0;
        end
      end
      S_READY: begin
        if (pix_en && active) begin
          pixel_on_d = buf_bit_c;
          bi_d       = bi_q + BIT_W'(1);
          state_d    = S_SHOW;
        end
      end
      S_SHOW: begin
        if (pix_en && active) begin
          pixel_on_d = buf_bit_c;
          bi_d       = bi_q + BIT_W'(1);
          if (bi_q == BIT_W'(7)) begin
            ci_d = ci_q + CIDX_W'(1);
            if (ci_q == CIDX_W'(NUM_CHARS - 1)) begin
              ci_d    = '0;
              bi_d    = '0;
              ready_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new line request wins over any pixel or capture in the same clock.
    if (line_start) begin
      state_d     = S_FETCH;
      row_d       = glyph_row;
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
      issued_d    = 1'b0;
      char_idx_d  = '0;
      rom_addr_d  = rom_addr_q;
      ready_d     = 1'b0;
      ci_d        = '0;
      bi_d        = '0;
      buf_we_c    = 1'b0;
      if (state_q != S_IDLE) pixel_on_d = 1'b0;
    end
  end

  assign char_idx = char_idx_q;
  assign rom_addr = rom_addr_q;
  assign ready    = ready_q;
  assign pixel_on = pixel_on_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_glyph_line_fetcher.sv
// Directed bench for glyph_line_fetcher: a time-since-line-start model is
// compared every cycle, plus literal expectations for the "SCORE" line.
module tb_glyph_line_fetcher;

  localparam int N  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_start;
  logic [3:0]    glyph_row;
  logic [CW-1:0] char_idx;
  logic [7:0]    char_code;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          pix_en;
  logic          active;
  logic          ready;
  logic          pixel_on;
  logic          underrun;

  int total = 0;
  int bad   = 0;

  // "SCORE" with bit 7 set on 'O', which the ROM address must ignore.
  logic [7:0] text [N] = '{8'h53, 8'h43, 8'hCF, 8'h52, 8'h45};

  glyph_line_fetcher #(.NUM_CHARS(N), .CIDX_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .glyph_row  (glyph_row),
    .char_idx   (char_idx),
    .char_code  (char_code),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_en     (pix_en),
    .active     (active),
    .ready      (ready),
    .pixel_on   (pixel_on),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    case (a)
      11'h532, 11'h432, 11'h4F2: rom_fn = 8'h7C;
      11'h522:                   rom_fn = 8'hFC;
      11'h452:                   rom_fn = 8'hFE;
      11'h534, 11'h434, 11'h454: rom_fn = 8'hC0;
      11'h4F4, 11'h524:          rom_fn = 8'hC6;
      default:                   rom_fn = 8'(int'(a[10:4]) * 29 + int'(a[3:0]) * 11 + 5);
    endcase
  endfunction

  always_comb begin
    char_code = 8'h20;
    for (int i = 0; i < N; i++) if (int'(char_idx) == i) char_code = text[i];
  end

  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: line progress measured in clocks since line_start and bits shown.
  int          m_mode;
  int          m_t;
  int          m_pos;
  logic [3:0]  m_row;
  logic        e_ready, e_pix, e_unr;
  logic [CW-1:0] e_idx;
  logic [10:0] e_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_t = 0; m_pos = 0; m_row = '0;
      e_ready = 0; e_pix = 0; e_unr = 0; e_idx = '0; e_addr = '0;
    end else begin
      e_unr = pix_en && active && !e_ready;
      if (line_start) begin
        if (m_mode != 0 || pix_en) e_pix = 0;
        m_mode = 1; m_t = 0; m_row = glyph_row; e_ready = 0; e_idx = '0;
      end else if (m_mode == 1) begin
        m_t++;
        if (m_t <= N) begin
          e_addr = {text[m_t-1][6:0], m_row};
          e_idx  = CW'((m_t < N) ? m_t : N - 1);
        end
        if (m_t == N + 2) begin
          m_mode = 2; e_ready = 1; m_pos = 0;
        end
        if (pix_en) e_pix = 0;
      end else if (m_mode == 2) begin
        if (pix_en) begin
          if (active) begin
            logic [7:0] g;
            g = rom_fn({text[m_pos/8][6:0], m_row});
            e_pix = g[7 - (m_pos % 8)];
            m_pos++;
            if (m_pos == 8 * N) begin
              m_mode = 0; e_ready = 0;
            end
          end else begin
            e_pix = 0;
          end
        end
      end else if (pix_en) begin
        e_pix = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("m_ready",    64'(ready),    64'(e_ready));
    check("m_pixel_on", 64'(pixel_on), 64'(e_pix));
    check("m_underrun", 64'(underrun), 64'(e_unr));
    check("m_char_idx", 64'(char_idx), 64'(e_idx));
    check("m_rom_addr", 64'(rom_addr), 64'(e_addr));
  end

  logic [39:0] bits;

  task automatic step(input logic ls, input logic [3:0] row, input logic pe, input logic act);
    line_start = ls; glyph_row = row; pix_en = pe; active = act;
    @(negedge clk);
    line_start = 0; pix_en = 0; active = 0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 20) begin
      step(0, 4'd0, 0, 0);
      n++;
    end
    check(nm, 64'(ready), 64'd1);
  endtask

  task automatic show(input int npix);
    for (int i = 0; i < npix; i++) begin
      step(0, 4'd0, 1, 1);
      bits = {bits[38:0], pixel_on};
    end
  endtask

  logic [10:0] exp_a [5] = '{11'h532, 11'h432, 11'h4F2, 11'h522, 11'h452};

  initial begin
    reset = 1; line_start = 0; glyph_row = 0; pix_en = 0; active = 0; bits = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_addr",  64'(rom_addr), 64'd0);
    check("rst_idx",   64'(char_idx), 64'd0);
    reset = 0;
    @(negedge clk);

    // 1: fetch latency and address sequence
    step(1, 4'd2, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 4'd0, 0, 0);
      if (k <= 5) check("t1_addr", 64'(rom_addr), 64'(exp_a[k-1]));
      if (k == 6) check("t1_ready_early", 64'(ready), 64'd0);
      if (k == 7) check("t1_ready", 64'(ready), 64'd1);
    end

    // 2: full line of pixels
    show(40);
    check("t2_bits", 64'(bits), 64'h7C7C7CFCFE);
    check("t2_ready_low", 64'(ready), 64'd0);

    // 3: pixel demand during fetch
    step(1, 4'd2, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 1);
    check("t3_underrun", 64'(underrun), 64'd1);
    check("t3_pixel", 64'(pixel_on), 64'd0);
    step(0, 4'd0, 0, 0);
    check("t3_underrun_pulse", 64'(underrun), 64'd0);
    wait_ready("t3_ready");
    show(40);
    check("t3_bits", 64'(bits), 64'h7C7C7CFCFE);

    // 4: line restart in the middle of the display
    step(1, 4'd2, 0, 0);
    wait_ready("t4_ready1");
    show(12);
    check("t4_pix_before", 64'(pixel_on), 64'd1);
    step(1, 4'd4, 1, 1);
    check("t4_pixel_abort", 64'(pixel_on), 64'd0);
    check("t4_ready_abort", 64'(ready), 64'd0);
    wait_ready("t4_ready2");
    show(40);
    check("t4_bits", 64'(bits), 64'hC0C0C6C6C0);

    // 5: inactive gap mid-character
    step(1, 4'd2, 0, 0);
    wait_ready("t5_ready");
    show(13);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'd0, 1, 0);
      check("t5_gap", 64'(pixel_on), 64'd0);
      step(0, 4'd0, 0, 0);
    end
    show(27);
    check("t5_bits", 64'(bits), 64'h7C7C7CFCFE);

    // 6: asynchronous reset during fetch
    step(1, 4'd2, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("t6_addr", 64'(rom_addr), 64'd0);
    check("t6_idx",  64'(char_idx), 64'd0);
    check("t6_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    step(1, 4'd3, 0, 0);
    wait_ready("t6_ready");
    show(40);
    check("t6_ready_low", 64'(ready), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
